dps_mode_ctrl: RTL

Strap and reset sequencer for the shared debug-port pins (DPS) on FPGA targets. It synchronises and debounces the SPI/JTAG select strap and the bootstrap strap, then latches the selected mode. It holds the system reset request low until the straps are locked, and it converts the JTAG system-reset pin into a stretched reset that re-samples the straps. It sits between the raw DPS pads and both the pad mux and `clkgen`.

---
 rtl/dps_pkg.sv | 32 +++
 rtl/prim_flop_2sync.sv | 27 ++
 rtl/dps_mode_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dps_pkg.sv
// Shared types and defaults for the debug-port strap/reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dps_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    SAMPLE    = 2'd1,
    LOCKED    = 2'd2,
    SRST_HOLD = 2'd3
  } dps_state_e;

  typedef enum logic {
    DpsJtag = 1'b0,
    DpsSpi  = 1'b1
  } dps_mode_e;

  localparam int unsigned DefDebounceCycles = 16;
  localparam int unsigned DefSrstStretch    = 8;
  localparam int unsigned DefSyncStages     = 2;

  // Largest of three values; sizes the shared sequencing counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for quasi-static pad inputs, with a per-instance reset value.
// Latency: 2 clk_i edges from d_i to q_o.
// Backpressure: none; samples every cycle.
module prim_flop_2sync #(
  parameter int unsigned      Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/dps_mode_ctrl.sv
// Synchronises/debounces the SPI-vs-JTAG and boot straps, latches the mode, sequences system reset.
// Latency: power-up lock at edge SyncStages+DebounceCycles; srst fall to reset request in SyncStages+1 edges.
// Backpressure: none; relatch_i is honoured only while LOCKED, otherwise dropped.
module dps_mode_ctrl
  import dps_pkg::*;
#(
  parameter int unsigned DebounceCycles = DefDebounceCycles,
  parameter int unsigned SrstStretch    = DefSrstStretch,
  parameter int unsigned SyncStages     = DefSyncStages
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strap_spi_i,
  input  logic strap_boot_i,
  input  logic jtag_srst_ni,
  input  logic relatch_i,
  output logic mode_spi_o,
  output logic bootstrap_o,
  output logic mode_valid_o,
  output logic jtag_en_o,
  output logic spi_en_o,
  output logic sys_rst_req_no
);

  // One counter serves the power-up wait, the debounce and the srst stretch.
  localparam int unsigned CntMax = max3(DebounceCycles, SrstStretch, SyncStages);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] SrstLast = CntW'(SrstStretch - 1);
  localparam logic [CntW-1:0] SyncLast = CntW'(SyncStages);

  // Raw pads bundled as {srst_n, spi, boot}; srst idles high, straps idle low.
  localparam logic [2:0] RawRst = 3'b100;

  logic [2:0]      raw;
  logic [2:0]      pre_out;
  logic [1:0]      strap_sync;   // {spi, boot}
  logic            srst_sync;
  dps_state_e      state;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;
  logic [1:0]      last;
  logic            lock_spi;

  assign raw = {jtag_srst_ni, strap_spi_i, strap_boot_i};

  generate
    if (SyncStages > 2) begin : g_pre
      logic [2:0] pre_q [SyncStages-2];

      // Extra leading stages for deeper synchronisation ahead of the 2-flop primitive.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < int'(SyncStages) - 2; i++) pre_q[i] <= RawRst;
        end else begin
          pre_q[0] <= raw;
          for (int i = 1; i < int'(SyncStages) - 2; i++) pre_q[i] <= pre_q[i-1];
        end
      end

      assign pre_out = pre_q[SyncStages-3];
    end else begin : g_nopre
      assign pre_out = raw;
    end
  endgenerate

  prim_flop_2sync #(
    .Width      (2),
    .ResetValue (2'b00)
  ) u_sync_strap (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pre_out[1:0]),
    .q_o    (strap_sync)
  );

  prim_flop_2sync #(
    .Width      (1),
    .ResetValue (1'b1)
  ) u_sync_srst (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pre_out[2]),
    .q_o    (srst_sync)
  );

  // Saturating increment so a stuck condition can never wrap into a false match.
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
  assign lock_spi = (dps_mode_e'(strap_sync[1]) == DpsSpi);

  // Sequencer: wait for synchronisers, debounce, lock, and stretch JTAG resets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= SYNC_WAIT;
      cnt            <= '0;
      last           <= 2'b00;
      mode_spi_o     <= 1'b0;
      bootstrap_o    <= 1'b0;
      mode_valid_o   <= 1'b0;
      jtag_en_o      <= 1'b0;
      spi_en_o       <= 1'b0;
      sys_rst_req_no <= 1'b0;
    end else begin
      case (state)
        SYNC_WAIT: begin
          // Leave only once the synchroniser holds real pad data. The value loaded
          // here is already a valid synced sample, so it counts as the first
          // stable cycle; this keeps power-up lock at SyncStages+DebounceCycles.
          if (cnt == SyncLast) begin
            state <= SAMPLE;
            last  <= strap_sync;
            cnt   <= CntW'(1);
          end else begin
            cnt <= cnt_inc;
          end
        end

        SAMPLE: begin
          if (strap_sync == last) begin
            if (cnt == DebLast) begin
              state          <= LOCKED;
              cnt            <= '0;
              mode_spi_o     <= lock_spi;
              bootstrap_o    <= strap_sync[0];
              mode_valid_o   <= 1'b1;
              jtag_en_o      <= ~lock_spi;
              spi_en_o       <= lock_spi;
              sys_rst_req_no <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt  <= '0;
            last <= strap_sync;
          end
        end

        LOCKED: begin
          // srst has priority over relatch; the srst pin is unused in SPI mode.
          if (!srst_sync && !mode_spi_o) begin
            state          <= SRST_HOLD;
            cnt            <= '0;
            mode_valid_o   <= 1'b0;
            jtag_en_o      <= 1'b0;
            spi_en_o       <= 1'b0;
            sys_rst_req_no <= 1'b0;
          end else if (relatch_i) begin
            state          <= SAMPLE;
            cnt            <= '0;
            last           <= strap_sync;
            mode_valid_o   <= 1'b0;
            jtag_en_o      <= 1'b0;
            spi_en_o       <= 1'b0;
            sys_rst_req_no <= 1'b0;
          end
        end

        SRST_HOLD: begin
          // Any low srst sample restarts the stretch.
          if (!srst_sync) begin
            cnt <= '0;
          end else if (cnt == SrstLast) begin
            state <= SAMPLE;
            cnt   <= '0;
            last  <= strap_sync;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= SYNC_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
